// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the memory-unit port between up to four requesters.
// Optional owner lock for read-modify-write sequences: define MEM_ARB_LOCK_EN.
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_func,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr1,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr2,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         rdata1,
    output logic [DATA_W-1:0]         rdata2,
    output logic                      mem_execute,
    output logic [1:0]                mem_func,
    output logic [ADDR_W-1:0]         address1,
    output logic [ADDR_W-1:0]         address2,
    output logic [DATA_W-1:0]         write_data,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         read_data1,
    input  logic [DATA_W-1:0]         read_data2,
    output logic                      busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       win_q, win_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                exec_q, exec_d;
    logic [1:0]          func_q, func_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic                busy_q, busy_d;
    logic                lock_q, lock_d;

    logic [1:0]          func_a  [NUM_REQ];
    logic [ADDR_W-1:0]   addr1_a [NUM_REQ];
    logic [ADDR_W-1:0]   addr2_a [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign func_a[g]  = req_func[2*g +: 2];
        assign addr1_a[g] = req_addr1[g*ADDR_W +: ADDR_W];
        assign addr2_a[g] = req_addr2[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

`ifndef MEM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Round-robin search begins at the slot after the last one served.
    logic          rr_found;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_idx   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    logic          take;
    logic [IW-1:0] sel;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        grant_d  = grant_q;
        ack_d    = '0;
        exec_d   = 1'b0;
        func_d   = func_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        wdata_d  = wdata_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        lock_d   = lock_q;
        take     = 1'b0;
        sel      = rr_pick;

        case (state_q)
            IDLE: begin
                // A locked owner is the only eligible slot; dropping req releases it.
                if (lock_q) begin
                    sel  = win_q;
                    take = req[win_q];
                    if (!req[win_q]) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                    end
                end else begin
                    take = rr_found;
                end
                if (take) begin
                    win_d        = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    func_d       = func_a[sel];
                    addr1_d      = addr1_a[sel];
                    addr2_d      = addr2_a[sel];
                    wdata_d      = wdata_a[sel];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                exec_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                func_d = 2'b00;
                if (mem_ready) begin
                    rdata1_d = read_data1;
                    rdata2_d = read_data2;
                    ack_d    = grant_q;
`ifdef MEM_ARB_LOCK_EN
                    lock_d   = req_lock[win_q];
`else
                    lock_d   = 1'b0;
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                last_d = win_q;
                if (!lock_q) begin
                    grant_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            win_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            exec_q   <= 1'b0;
            func_q   <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            busy_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            exec_q   <= exec_d;
            func_q   <= func_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            busy_q   <= busy_d;
            lock_q   <= lock_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign rdata1      = rdata1_q;
    assign rdata2      = rdata2_q;
    assign mem_execute = exec_q;
    assign mem_func    = func_q;
    assign address1    = addr1_q;
    assign address2    = addr2_q;
    assign write_data  = wdata_q;
    assign busy        = busy_q;

endmodule
